// File: rtl/word_collect_pkg.sv
// Shared definitions for the serial word collector: default word width and FSM states.
package word_collect_pkg;

    localparam int WORD_W_DEF = 12;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_e;

endpackage

// File: rtl/word_collect_if.sv
// Bit-stream input and assembled-word output bundle of the word collector.
interface word_collect_if
    import word_collect_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF
) ();

    logic              bit_in;
    logic              bit_valid;
    logic              word_start;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              frame_err;
    logic              busy;

    modport master (
        output bit_in, bit_valid, word_start,
        input  word_out, word_valid, frame_err, busy
    );

    modport slave (
        input  bit_in, bit_valid, word_start,
        output word_out, word_valid, frame_err, busy
    );

endinterface

// File: rtl/word_collect_dffrn.sv
// Plain register with asynchronous active-low clear to zero.
module word_collect_dffrn #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else      q <= d;
    end

endmodule

// File: rtl/word_collect.sv
// Reassembles MSB-first serial bits into words, with optional differential decode,
// inter-bit gap timeout and mid-word restart detection.
module word_collect
    import word_collect_pkg::*;
#(
    parameter int WORD_W      = WORD_W_DEF,
    parameter int GAP_MAX     = 16,
    parameter bit DIFF_DECODE = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    word_collect_if.slave bus
);

    localparam int CNT_W = $clog2(WORD_W + 1);
    localparam int GAP_W = (GAP_MAX > 0) ? $clog2(GAP_MAX + 1) : 1;

    logic              state_q_bit, state_d_bit;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [WORD_W-1:0] wout_q, wout_d;
    logic              prev_q, prev_d;
    logic              wv_q, wv_d;
    logic              fe_q, fe_d;
    logic              dbit;

    assign state_q     = state_e'(state_q_bit);
    assign state_d_bit = state_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        sh_d    = sh_q;
        wout_d  = wout_q;
        prev_d  = prev_q;
        wv_d    = 1'b0;
        fe_d    = 1'b0;
        dbit    = DIFF_DECODE ? (bus.bit_in ^ prev_q) : bus.bit_in;

        if (bus.bit_valid) begin
            prev_d = bus.bit_in;
            gap_d  = '0;
            // A bit in IDLE, or a restart strobe mid-word, always opens a fresh word.
            if (state_q == IDLE || bus.word_start) begin
                fe_d    = (state_q == COLLECT);
                sh_d    = {{(WORD_W-1){1'b0}}, dbit};
                cnt_d   = CNT_W'(1);
                state_d = COLLECT;
            end else begin
                sh_d = {sh_q[WORD_W-2:0], dbit};
                if (cnt_q == CNT_W'(WORD_W - 1)) begin
                    wout_d  = sh_d;
                    wv_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end else if (state_q == COLLECT && GAP_MAX > 0) begin
            if (gap_q == GAP_W'(GAP_MAX - 1)) begin
                fe_d    = 1'b1;
                cnt_d   = '0;
                gap_d   = '0;
                sh_d    = '0;
                state_d = IDLE;
            end else if (gap_q != GAP_W'(GAP_MAX)) begin
                gap_d = gap_q + 1'b1;
            end
        end
    end

    word_collect_dffrn #(.W(1))      u_state (.clk(clk), .rst(rst), .d(state_d_bit), .q(state_q_bit));
    word_collect_dffrn #(.W(CNT_W))  u_cnt   (.clk(clk), .rst(rst), .d(cnt_d),       .q(cnt_q));
    word_collect_dffrn #(.W(GAP_W))  u_gap   (.clk(clk), .rst(rst), .d(gap_d),       .q(gap_q));
    word_collect_dffrn #(.W(WORD_W)) u_sh    (.clk(clk), .rst(rst), .d(sh_d),        .q(sh_q));
    word_collect_dffrn #(.W(WORD_W)) u_wout  (.clk(clk), .rst(rst), .d(wout_d),      .q(wout_q));
    word_collect_dffrn #(.W(1))      u_prev  (.clk(clk), .rst(rst), .d(prev_d),      .q(prev_q));
    word_collect_dffrn #(.W(1))      u_wv    (.clk(clk), .rst(rst), .d(wv_d),        .q(wv_q));
    word_collect_dffrn #(.W(1))      u_fe    (.clk(clk), .rst(rst), .d(fe_d),        .q(fe_q));

    assign bus.word_out   = wout_q;
    assign bus.word_valid = wv_q;
    assign bus.frame_err  = fe_q;
    assign bus.busy       = (state_q == COLLECT);

endmodule

// File: tb/tb_word_collect.sv
// Bench for word_collect: plain and differential instances share one directed stream.
module tb_word_collect;
    import word_collect_pkg::*;

    localparam int W  = 12;
    localparam int GM = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic bi = 1'b0, bv = 1'b0, ws = 1'b0;
    logic last_raw = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    word_collect_if #(.WORD_W(W)) if0 ();
    word_collect_if #(.WORD_W(W)) if1 ();

    assign if0.bit_in = bi;  assign if0.bit_valid = bv;  assign if0.word_start = ws;
    assign if1.bit_in = bi;  assign if1.bit_valid = bv;  assign if1.word_start = ws;

    word_collect #(.WORD_W(W), .GAP_MAX(GM), .DIFF_DECODE(1'b0)) u_plain (
        .clk(clk), .rst(rst), .bus(if0)
    );
    word_collect #(.WORD_W(W), .GAP_MAX(GM), .DIFF_DECODE(1'b1)) u_diff (
        .clk(clk), .rst(rst), .bus(if1)
    );

    // Behavioural model: a bit count, a gap count and an accumulator per instance.
    typedef struct {
        int           cnt;
        int           gap;
        logic [W-1:0] acc;
        logic [W-1:0] wo;
        logic         prev;
        logic         wv;
        logic         fe;
    } mst_t;

    mst_t m[2];

    function automatic mst_t mzero();
        mst_t z;
        z.cnt = 0; z.gap = 0; z.acc = '0; z.wo = '0;
        z.prev = 1'b0; z.wv = 1'b0; z.fe = 1'b0;
        return z;
    endfunction

    function automatic mst_t mstep(mst_t s, bit diff, logic v, logic b, logic st);
        mst_t n = s;
        logic d;
        n.wv = 1'b0;
        n.fe = 1'b0;
        if (v) begin
            d      = diff ? (b ^ s.prev) : b;
            n.prev = b;
            n.gap  = 0;
            if (s.cnt > 0 && st) begin
                n.fe  = 1'b1;
                n.acc = {{(W-1){1'b0}}, d};
                n.cnt = 1;
            end else begin
                n.acc = (s.cnt == 0) ? {{(W-1){1'b0}}, d} : {s.acc[W-2:0], d};
                n.cnt = s.cnt + 1;
                if (n.cnt == W) begin
                    n.wo  = n.acc;
                    n.wv  = 1'b1;
                    n.cnt = 0;
                end
            end
        end else if (s.cnt > 0) begin
            n.gap = s.gap + 1;
            if (n.gap == GM) begin
                n.fe  = 1'b1;
                n.cnt = 0;
                n.gap = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m[0] <= mzero();
            m[1] <= mzero();
        end else begin
            m[0] <= mstep(m[0], 1'b0, bv, bi, ws);
            m[1] <= mstep(m[1], 1'b1, bv, bi, ws);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("p.word_out",   32'(if0.word_out),   32'(m[0].wo));
        chk("p.word_valid", 32'(if0.word_valid), 32'(m[0].wv));
        chk("p.frame_err",  32'(if0.frame_err),  32'(m[0].fe));
        chk("p.busy",       32'(if0.busy),       32'(m[0].cnt > 0));
        chk("d.word_out",   32'(if1.word_out),   32'(m[1].wo));
        chk("d.word_valid", 32'(if1.word_valid), 32'(m[1].wv));
        chk("d.frame_err",  32'(if1.frame_err),  32'(m[1].fe));
        chk("d.busy",       32'(if1.busy),       32'(m[1].cnt > 0));
    end

    // Inputs change on the falling edge; each call returns one full cycle later.
    task automatic drive(input logic b, input logic v, input logic s);
        bi = b; bv = v; ws = s;
        if (v) last_raw = b;
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        drive(b, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) send_bit(w[i]);
    endtask

    task automatic send_enc(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) send_bit(w[i] ^ last_raw);
    endtask

    initial begin
        logic [W-1:0] w;
        repeat (2) @(negedge clk);
        chk("rst.word_out", 32'(if0.word_out), 32'h0);
        chk("rst.busy",     32'(if0.busy),     32'h0);
        chk("rst.valid",    32'(if0.word_valid), 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // 1: single word
        w = 12'hA5C;
        send_bits(w, 11, 1);
        chk("t1.busy_mid", 32'(if0.busy), 32'h1);
        chk("t1.valid_mid", 32'(if0.word_valid), 32'h0);
        send_bits(w, 0, 0);
        chk("t1.valid", 32'(if0.word_valid), 32'h1);
        chk("t1.word",  32'(if0.word_out),   32'hA5C);
        chk("t1.ferr",  32'(if0.frame_err),  32'h0);
        chk("t1.busy",  32'(if0.busy),       32'h0);

        // 2: back-to-back words
        send_bits(12'hFFF, 11, 0);
        chk("t2.valid1", 32'(if0.word_valid), 32'h1);
        chk("t2.word1",  32'(if0.word_out),   32'hFFF);
        send_bits(12'h001, 11, 1);
        chk("t2.gap_valid", 32'(if0.word_valid), 32'h0);
        send_bits(12'h001, 0, 0);
        chk("t2.valid2", 32'(if0.word_valid), 32'h1);
        chk("t2.word2",  32'(if0.word_out),   32'h001);

        // 3: gap timeout and tolerated gap
        idle(1);
        send_bits(12'hB00, 11, 7);
        idle(15);
        chk("t3.no_err15", 32'(if0.frame_err), 32'h0);
        chk("t3.busy15",   32'(if0.busy),      32'h1);
        idle(1);
        chk("t3.ferr",     32'(if0.frame_err), 32'h1);
        chk("t3.busy",     32'(if0.busy),      32'h0);
        chk("t3.word_hold", 32'(if0.word_out), 32'h001);
        send_bits(12'h7E2, 11, 0);
        chk("t3.word_a", 32'(if0.word_out), 32'h7E2);
        send_bits(12'h9C4, 11, 6);
        idle(15);
        chk("t3.gap15_busy", 32'(if0.busy), 32'h1);
        send_bits(12'h9C4, 5, 0);
        chk("t3.valid_b", 32'(if0.word_valid), 32'h1);
        chk("t3.word_b",  32'(if0.word_out),   32'h9C4);

        // 4: restart mid-word
        send_bits(12'h333, 11, 5);
        w = 12'h6B5;
        drive(w[11], 1'b1, 1'b1);
        chk("t4.ferr",  32'(if0.frame_err),  32'h1);
        chk("t4.busy",  32'(if0.busy),       32'h1);
        chk("t4.word_hold", 32'(if0.word_out), 32'h9C4);
        send_bits(w, 10, 0);
        chk("t4.valid", 32'(if0.word_valid), 32'h1);
        chk("t4.word",  32'(if0.word_out),   32'h6B5);

        // 5: differential decode from a fresh reset
        rst = 1'b0; last_raw = 1'b0;
        idle(1);
        rst = 1'b1;
        send_enc(12'h3C9);
        chk("t5.valid1", 32'(if1.word_valid), 32'h1);
        chk("t5.word1",  32'(if1.word_out),   32'h3C9);
        send_enc(12'h5A3);
        chk("t5.word2",  32'(if1.word_out),   32'h5A3);

        // 6: asynchronous reset mid-word
        idle(2);
        send_bits(12'hFFF, 11, 7);
        #2 rst = 1'b0;
        #1;
        chk("t6.busy",  32'(if0.busy),       32'h0);
        chk("t6.word",  32'(if0.word_out),   32'h0);
        chk("t6.dword", 32'(if1.word_out),   32'h0);
        chk("t6.ferr",  32'(if0.frame_err),  32'h0);
        #3 rst = 1'b1;
        last_raw = 1'b0;
        @(negedge clk);
        send_bits(12'hC3A, 11, 0);
        chk("t6.valid", 32'(if0.word_valid), 32'h1);
        chk("t6.word_after", 32'(if0.word_out), 32'hC3A);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
